// File: rtl/bit_lane_deser.sv
// bit_lane_deser: packs a 1-bit-per-cycle lane stream into WIDTH-bit words.
// The bit side and the word side each use a valid/ready handshake. A single
// output holding register sits on the word side. The block sustains one bit
// per cycle with no bubble between consecutive words.
// bit_ready_o is combinational from flush_i and word_ready_i: the last bit of
// a word can only be taken when the output register is free this cycle.
module bit_lane_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     bit_valid_i,
  input  logic                     bit_i,
  output logic                     bit_ready_o,
  input  logic                     flush_i,
  output logic                     word_valid_o,
  output logic [WIDTH-1:0]         word_o,
  input  logic                     word_ready_i,
  output logic [$clog2(WIDTH)-1:0] count_o
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q;

  logic             out_free;
  logic             last_bit;
  logic             bit_accept;
  logic             consume;
  logic [CW-1:0]    bit_pos;
  logic [WIDTH-1:0] acc_ins;

  // Handshake decode: the output is free when empty or being drained now,
  // and the last bit of a word may only enter when the output is free.
  always_comb begin
    out_free    = !word_valid_q || word_ready_i;
    last_bit    = (cnt_q == LAST_IDX);
    bit_ready_o = !flush_i && (!last_bit || out_free);
    bit_accept  = bit_valid_i && bit_ready_o;
    consume     = word_valid_q && word_ready_i;
  end

  // Accumulator with the incoming bit merged at its lane position; used both
  // for the partial-word update and for loading the completed word.
  always_comb begin
    bit_pos          = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
    acc_ins          = acc_q;
    acc_ins[bit_pos] = bit_i;
  end

  // Partial-word accumulator and bit counter; flush and word completion
  // both restart assembly from an empty accumulator.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (bit_accept) begin
      if (last_bit) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_ins;
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Output holding register: a completed word loads even while the previous
  // one is being consumed, which keeps valid high for back-to-back words.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else if (bit_accept && last_bit) begin
      word_q       <= acc_ins;
      word_valid_q <= 1'b1;
    end else if (consume) begin
      word_valid_q <= 1'b0;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign count_o      = cnt_q;

endmodule

// File: tb/tb_bit_lane_deser.sv
// tb_bit_lane_deser: directed and scoreboard checks for bit_lane_deser.
// Two instances share every input: one LSB-first, one MSB-first, so each
// stimulus checks both lane orders at once.
module tb_bit_lane_deser;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       bit_valid_i;
  logic       bit_i;
  logic       flush_i;
  logic       word_ready_i;

  logic       bit_ready_l, bit_ready_m;
  logic       word_valid_l, word_valid_m;
  logic [3:0] word_l, word_m;
  logic [1:0] count_l, count_m;

  int n_checks = 0;
  int n_fail   = 0;

  logic       sb_en = 1'b0;
  logic [3:0] q_l[$];
  logic [3:0] q_m[$];
  int         n_popped = 0;

  bit_lane_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_i(clk_i), .rst_ni(rst_ni), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .bit_ready_o(bit_ready_l), .flush_i(flush_i), .word_valid_o(word_valid_l),
    .word_o(word_l), .word_ready_i(word_ready_i), .count_o(count_l));

  bit_lane_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk_i), .rst_ni(rst_ni), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .bit_ready_o(bit_ready_m), .flush_i(flush_i), .word_valid_o(word_valid_m),
    .word_o(word_m), .word_ready_i(word_ready_i), .count_o(count_m));

  // Free-running clock, 10 time units per period.
  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] rev4(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every consume seen half a cycle before its edge pops
  // one expected word per instance.
  always @(negedge clk_i) begin
    if (sb_en && word_valid_l && word_ready_i) begin
      n_checks++;
      if (q_l.size() == 0 || q_m.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL sb_extra_word: got lsb=%h msb=%h, expected no word", word_l, word_m);
      end else begin
        logic [3:0] el, em;
        el = q_l.pop_front();
        em = q_m.pop_front();
        n_popped++;
        if (word_l !== el || word_m !== em || word_valid_m !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL sb_word: got lsb=%h msb=%h vm=%b, expected lsb=%h msb=%h vm=1",
                   word_l, word_m, word_valid_m, el, em);
        end
      end
    end
  end

  task automatic test_reset();
    rst_ni = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0; flush_i = 1'b0; word_ready_i = 1'b1;
    #12;
    n_checks++;
    if (word_valid_l !== 1'b0 || word_l !== 4'h0 || count_l !== 2'd0 ||
        word_valid_m !== 1'b0 || word_m !== 4'h0 || count_m !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got vl=%b wl=%h cl=%0d vm=%b wm=%h cm=%0d, expected all zero",
               word_valid_l, word_l, count_l, word_valid_m, word_m, count_m);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    n_checks++;
    if (bit_ready_l !== 1'b1 || bit_ready_m !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %b/%b, expected 1/1", bit_ready_l, bit_ready_m);
    end
  endtask

  task automatic test_lsb_basic();
    logic [3:0] pat;
    pat = 4'b1010;
    word_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_valid_i = 1'b1; bit_i = pat[i];
      n_checks++;
      if (count_l !== 2'(i)) begin
        n_fail++;
        $display("[TB] FAIL basic_count: got %0d, expected %0d", count_l, i);
      end
      step();
    end
    bit_valid_i = 1'b0;
    n_checks++;
    if (word_valid_l !== 1'b1 || word_l !== 4'ha || word_m !== 4'h5 || count_l !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL basic_word: got v=%b wl=%h wm=%h c=%0d, expected v=1 wl=a wm=5 c=0",
               word_valid_l, word_l, word_m, count_l);
    end
    step();
    n_checks++;
    if (word_valid_l !== 1'b0 || word_l !== 4'ha) begin
      n_fail++;
      $display("[TB] FAIL basic_consume: got v=%b w=%h, expected v=0 w=a", word_valid_l, word_l);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pats[3];
    logic [3:0] exp_l[3];
    logic [3:0] exp_m[3];
    pats  = '{4'b0101, 4'b1111, 4'b0000};
    exp_l = '{4'h5, 4'hf, 4'h0};
    exp_m = '{4'ha, 4'hf, 4'h0};
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        word_ready_i = (k == 3);
        bit_valid_i  = 1'b1;
        bit_i        = pats[w][k];
        step();
        if (w > 0 || k == 3) begin
          int e;
          e = (k == 3) ? w : w - 1;
          n_checks++;
          if (word_valid_l !== 1'b1 || word_valid_m !== 1'b1 ||
              word_l !== exp_l[e] || word_m !== exp_m[e]) begin
            n_fail++;
            $display("[TB] FAIL b2b_word: got vl=%b vm=%b wl=%h wm=%h, expected v=1 wl=%h wm=%h",
                     word_valid_l, word_valid_m, word_l, word_m, exp_l[e], exp_m[e]);
          end
        end
      end
    end
    bit_valid_i = 1'b0; word_ready_i = 1'b1;
    step();
    n_checks++;
    if (word_valid_l !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_drain: got v=%b, expected 0", word_valid_l);
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    pat = 4'b1010;
    word_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid_i = 1'b1; bit_i = pat[i];
      step();
    end
    bit_i = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bit_ready_l !== 1'b0 || count_l !== 2'd3 || word_l !== 4'ha || word_valid_l !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_hold: got r=%b c=%0d w=%h v=%b, expected r=0 c=3 w=a v=1",
               bit_ready_l, count_l, word_l, word_valid_l);
    end
    step();
    n_checks++;
    if (count_l !== 2'd3 || word_l !== 4'ha || word_m !== 4'h5) begin
      n_fail++;
      $display("[TB] FAIL stall_stable: got c=%0d wl=%h wm=%h, expected c=3 wl=a wm=5",
               count_l, word_l, word_m);
    end
    word_ready_i = 1'b1;
    #1;
    n_checks++;
    if (bit_ready_l !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL stall_release_ready: got %b, expected 1", bit_ready_l);
    end
    step();
    n_checks++;
    if (word_l !== 4'hf || word_m !== 4'hf || word_valid_l !== 1'b1 || count_l !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL stall_release_word: got wl=%h wm=%h v=%b c=%0d, expected f f 1 0",
               word_l, word_m, word_valid_l, count_l);
    end
    bit_valid_i = 1'b0;
    step();
  endtask

  task automatic test_flush();
    logic [3:0] pat;
    word_ready_i = 1'b1;
    bit_valid_i = 1'b1; bit_i = 1'b1;
    repeat (2) step();
    n_checks++;
    if (count_l !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL flush_precount: got %0d, expected 2", count_l);
    end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (bit_ready_l !== 1'b0 || bit_ready_m !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_ready: got %b/%b, expected 0/0", bit_ready_l, bit_ready_m);
    end
    step();
    flush_i = 1'b0;
    n_checks++;
    if (count_l !== 2'd0 || count_m !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL flush_count: got %0d/%0d, expected 0/0", count_l, count_m);
    end
    pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      bit_i = pat[i];
      step();
    end
    bit_valid_i = 1'b0;
    n_checks++;
    if (word_valid_l !== 1'b1 || word_l !== 4'ha || word_m !== 4'h5) begin
      n_fail++;
      $display("[TB] FAIL flush_word: got v=%b wl=%h wm=%h, expected v=1 wl=a wm=5",
               word_valid_l, word_l, word_m);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [3:0] pat;
    pat = 4'b1010;
    word_ready_i = 1'b0;
    bit_valid_i  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_i = pat[i];
      step();
    end
    bit_i = 1'b1;
    repeat (2) step();
    bit_valid_i = 1'b0;
    n_checks++;
    if (count_l !== 2'd2 || word_valid_l !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: got c=%0d v=%b, expected c=2 v=1", count_l, word_valid_l);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if (word_valid_l !== 1'b0 || word_l !== 4'h0 || count_l !== 2'd0 ||
        word_valid_m !== 1'b0 || word_m !== 4'h0 || count_m !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL areset_immediate: got vl=%b wl=%h cl=%0d vm=%b wm=%h cm=%0d, expected zeros",
               word_valid_l, word_l, count_l, word_valid_m, word_m, count_m);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
    word_ready_i = 1'b1;
    bit_valid_i  = 1'b1;
    pat = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      bit_i = pat[i];
      step();
    end
    bit_valid_i = 1'b0;
    n_checks++;
    if (word_valid_l !== 1'b1 || word_l !== 4'h3 || word_m !== 4'hc) begin
      n_fail++;
      $display("[TB] FAIL areset_fresh: got v=%b wl=%h wm=%h, expected v=1 wl=3 wm=c",
               word_valid_l, word_l, word_m);
    end
    step();
  endtask

  task automatic test_gapped_scoreboard();
    logic [3:0] d;
    logic       took;
    int         tries;
    int         drain;
    sb_en = 1'b1;
    for (int w = 0; w < 100; w++) begin
      d = 4'($urandom_range(0, 15));
      q_l.push_back(d);
      q_m.push_back(rev4(d));
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) begin
          bit_valid_i  = 1'b0;
          word_ready_i = 1'($urandom_range(0, 1));
          step();
        end
        bit_valid_i = 1'b1;
        bit_i       = d[i];
        took        = 1'b0;
        tries       = 0;
        while (!took && tries < 50) begin
          word_ready_i = 1'($urandom_range(0, 1));
          #1;
          took = bit_ready_l;
          step();
          tries++;
        end
        if (!took) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL sb_bit_timeout: got no accept in %0d cycles, expected accept", tries);
        end
      end
    end
    bit_valid_i  = 1'b0;
    word_ready_i = 1'b1;
    drain = 0;
    while (q_l.size() != 0 && drain < 20) begin
      step();
      drain++;
    end
    step();
    sb_en = 1'b0;
    n_checks++;
    if (q_l.size() != 0 || n_popped != 100) begin
      n_fail++;
      $display("[TB] FAIL sb_total: got %0d words consumed with %0d left, expected 100 and 0",
               n_popped, q_l.size());
    end
  endtask

  // Main sequence: each scenario task drives its own stimulus and checks.
  initial begin
    test_reset();
    test_lsb_basic();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_gapped_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion by time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
